// File: rtl/key_expansion_ctrl.sv
// rtl/key_expansion_ctrl.sv - AES-128 key expansion controller with an 11-entry round-key buffer
// Optional build macro: KEY_EXP_ZEROIZE_EN (adds the zeroize input).

// One AES-128 key-schedule step: previous round key -> next round key
module key_scheduler (
    input  logic [0:3]   round_in,
    input  logic [0:127] key_in,
    output logic [0:127] out
);

    // AES S-box, entry n occupies bits [8n +: 8]
    localparam logic [0:2047] sbox_rom = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return sbox_rom[{b, 3'b000} +: 8];
    endfunction

    logic [0:31] w0, w1, w2, w3;
    logic [0:31] temp;
    logic [0:31] n0, n1, n2, n3;
    logic [0:7]  rcon;

    // Round constant for rounds 1..10; anything else contributes nothing
    always_comb begin
        rcon = 8'h00;
        case (round_in)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign w0 = key_in[0:31];
    assign w1 = key_in[32:63];
    assign w2 = key_in[64:95];
    assign w3 = key_in[96:127];

    // SubWord(RotWord(w3)) xor Rcon
    assign temp = {sub_byte(w3[8:15]), sub_byte(w3[16:23]),
                   sub_byte(w3[24:31]), sub_byte(w3[0:7])} ^ {rcon, 24'h000000};

    assign n0  = w0 ^ temp;
    assign n1  = w1 ^ n0;
    assign n2  = w2 ^ n1;
    assign n3  = w3 ^ n2;
    assign out = {n0, n1, n2, n3};

endmodule

module key_expansion_ctrl (
    input  logic         clk,
    input  logic         rst,
`ifdef KEY_EXP_ZEROIZE_EN
    input  logic         zeroize,
`endif
    input  logic         start,
    input  logic [0:127] key_in,
    input  logic [0:3]   rd_addr,
    output logic [0:127] rk_out,
    output logic         busy,
    output logic         done,
    output logic         keys_valid
);

    typedef enum logic {IDLE, EXPAND} state_t;

    state_t       state;
    logic [3:0]   round_cnt;
    logic [0:127] rk [0:10];
    logic [0:3]   sched_round;
    logic [0:127] sched_key;
    logic [0:127] sched_out;
    logic         clear;

`ifdef KEY_EXP_ZEROIZE_EN
    assign clear = rst | zeroize;
`else
    assign clear = rst;
`endif

    // Scheduler sees the previous round key while expanding, zeros when idle
    always_comb begin
        sched_round = (state == EXPAND) ? round_cnt : 4'd0;
        sched_key   = '0;
        for (int i = 0; i < 10; i++) begin
            if (state == EXPAND && round_cnt == 4'(i + 1))
                sched_key = rk[i];
        end
    end

    key_scheduler u_key_scheduler (
        .round_in (sched_round),
        .key_in   (sched_key),
        .out      (sched_out)
    );

    // Combinational read port; indices past 10 read as zero
    always_comb begin
        rk_out = '0;
        for (int i = 0; i < 11; i++) begin
            if (rd_addr == 4'(i))
                rk_out = rk[i];
        end
    end

    // Control FSM and round-key buffer; clear wins over everything
    always_ff @(posedge clk) begin
        if (clear) begin
            state      <= IDLE;
            round_cnt  <= 4'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            keys_valid <= 1'b0;
            for (int i = 0; i < 11; i++)
                rk[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rk[0]      <= key_in;
                        round_cnt  <= 4'd1;
                        keys_valid <= 1'b0;
                        busy       <= 1'b1;
                        state      <= EXPAND;
                    end
                end
                EXPAND: begin
                    for (int i = 1; i < 11; i++) begin
                        if (round_cnt == 4'(i))
                            rk[i] <= sched_out;
                    end
                    if (round_cnt >= 4'd10) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        keys_valid <= 1'b1;
                        round_cnt  <= 4'd0;
                    end else begin
                        round_cnt  <= round_cnt + 4'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    round_cnt <= 4'd0;
                end
            endcase
        end
    end

endmodule
